// File: rtl/clk_div_multi_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  // Channel-select width; a single channel still needs a 1-bit select.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_CHANNELS = 4;
  localparam int CHAN_W       = chan_w(DEF_CHANNELS);

  // ceil(p/2) without an adder carry into a wider result.
  function automatic logic [31:0] half_up(input logic [31:0] p);
    return (p >> 1) + {31'd0, p[0]};
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Config write port: valid/ready handshake plus a one-cycle reject pulse.
interface clk_div_multi_if #(
  parameter int CHAN_W    = 2,
  parameter int CNT_WIDTH = 16
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CHAN_W-1:0]    cfg_chan;
  logic [CNT_WIDTH-1:0] cfg_div;
  logic                 cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_div,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_div,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clk_div_multi_chan.sv
// One divider channel: counter, active/pending period and registered outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clk_in,
  input  logic                 arst,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 wr,
  input  logic [CNT_WIDTH-1:0] wr_div,
  output logic                 pend,
  output logic                 div_out,
  output logic                 tick
);

  localparam logic [CNT_WIDTH-1:0] DEF_P = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);

  chan_state_t          state;
  logic [CNT_WIDTH-1:0] cnt, per, q;
  logic [CNT_WIDTH-1:0] per_nxt, cnt_nxt, half;
  logic                 restart, wrap, boundary, apply;

  // A pending period only lands on a boundary, or straight away when idle,
  // so the output never sees a half-finished period.
  always_comb begin
    restart  = en && ((state == IDLE) || sync);
    wrap     = en && (state == RUN) && (cnt == per - ONE);
    boundary = restart || wrap;
    apply    = pend && (boundary || (state == IDLE));
    per_nxt  = apply ? q : per;
    cnt_nxt  = boundary ? '0 : cnt + ONE;
    half     = CNT_WIDTH'(half_up(32'(per_nxt)));
  end

  always_ff @(posedge clk_in or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      cnt     <= '0;
      per     <= DEF_P;
      q       <= DEF_P;
      pend    <= 1'b0;
      div_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      per <= per_nxt;
      // Writes are only accepted with pend clear, so they never race an apply.
      if (wr && !pend) begin
        q    <= wr_div;
        pend <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
      if (!en) begin
        state   <= IDLE;
        cnt     <= '0;
        tick    <= 1'b0;
        div_out <= 1'b0;
      end else begin
        state   <= RUN;
        cnt     <= cnt_nxt;
        tick    <= boundary;
        div_out <= (cnt_nxt < half);
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable divider: config decode plus an array of channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                clk_in,
  input  logic                arst,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  clk_div_multi_if.slave      cfg,
  output logic [CHANNELS-1:0] div_out,
  output logic [CHANNELS-1:0] tick
);

  localparam int CW = chan_w(CHANNELS);

  logic [CHANNELS-1:0] pend, wr;
  logic                bad, pend_sel;

  // Rejected writes are always ready so a bad request can never stall the port.
  always_comb begin
    bad      = (cfg.cfg_div == '0) ||
               ({1'b0, cfg.cfg_chan} >= (CW+1)'(CHANNELS));
    pend_sel = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg.cfg_chan == CW'(i)) pend_sel = pend[i];
      wr[i] = cfg.cfg_valid && !bad && (cfg.cfg_chan == CW'(i)) && !pend[i];
    end
  end

  assign cfg.cfg_ready = bad || !pend_sel;

  always_ff @(posedge clk_in or posedge arst) begin
    if (arst) cfg.cfg_err <= 1'b0;
    else      cfg.cfg_err <= cfg.cfg_valid && bad;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clk_div_chan #(
      .CNT_WIDTH   (CNT_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .arst    (arst),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .wr_div  (cfg.cfg_div),
      .pend    (pend[g]),
      .div_out (div_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: hand vectors for corner cases plus a random run
// checked against a phase/period reference model.
module tb_clk_div_multi;

  localparam int CH  = 5;
  localparam int CW  = 3;
  localparam int DEF = 2;

  logic          clk_in, arst, sync;
  logic [CH-1:0] en, div_out, tick;

  clk_div_multi_if #(.CHAN_W(CW), .CNT_WIDTH(16)) cfg ();

  clk_div_multi #(.CHANNELS(CH), .CNT_WIDTH(16), .DEFAULT_DIV(DEF)) dut (
    .clk_in  (clk_in),
    .arst    (arst),
    .en      (en),
    .sync    (sync),
    .cfg     (cfg),
    .div_out (div_out),
    .tick    (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: each channel is a phase inside a period.
  int m_ph[CH], m_per[CH], m_q[CH];
  bit m_run[CH], m_pend[CH];
  logic rdy_s;

  typedef struct {
    logic [CH-1:0] en;
    logic          exp_tick0;
    logic          exp_div0;
  } vec_t;
  vec_t tv[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_ph[i] = 0; m_per[i] = DEF; m_q[i] = DEF; m_run[i] = 0; m_pend[i] = 0;
    end
  endtask

  task automatic step(input logic [CH-1:0] e, input logic s, input logic v,
                      input int c, input int d);
    logic bad, exp_rdy, ee, acc;
    logic [CH-1:0] et, ed;
    en = e; sync = s;
    cfg.cfg_valid = v; cfg.cfg_chan = CW'(c); cfg.cfg_div = 16'(d);
    #1;
    bad     = (d == 0) || (c >= CH);
    exp_rdy = bad ? 1'b1 : !m_pend[c];
    rdy_s   = cfg.cfg_ready;
    chk("cfg_ready", rdy_s, exp_rdy);
    @(posedge clk_in);
    for (int i = 0; i < CH; i++) begin
      acc = v && !bad && (c == i) && !m_pend[i];
      if (!e[i]) begin
        if (!m_run[i] && m_pend[i]) begin m_per[i] = m_q[i]; m_pend[i] = 0; end
        m_run[i] = 0; m_ph[i] = 0;
      end else if (!m_run[i] || s || (m_ph[i] + 1 >= m_per[i])) begin
        if (m_pend[i]) begin m_per[i] = m_q[i]; m_pend[i] = 0; end
        m_run[i] = 1; m_ph[i] = 0;
      end else begin
        m_ph[i]++;
      end
      if (acc) begin m_q[i] = d; m_pend[i] = 1; end
    end
    ee = v && bad;
    #1;
    for (int i = 0; i < CH; i++) begin
      et[i] = m_run[i] && (m_ph[i] == 0);
      ed[i] = m_run[i] && (m_ph[i] < (m_per[i] + 1) / 2);
    end
    chk("tick", tick, et);
    chk("div_out", div_out, ed);
    chk("cfg_err", cfg.cfg_err, ee);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nt, nh, both;
    logic [CH-1:0] re;

    tv[0] = '{5'b00001, 1'b1, 1'b1};
    tv[1] = '{5'b00001, 1'b0, 1'b0};
    tv[2] = '{5'b00001, 1'b1, 1'b1};
    tv[3] = '{5'b00001, 1'b0, 1'b0};
    tv[4] = '{5'b00001, 1'b1, 1'b1};
    tv[5] = '{5'b00001, 1'b0, 1'b0};

    arst = 1'b1; en = '0; sync = 1'b0;
    cfg.cfg_valid = 1'b0; cfg.cfg_chan = '0; cfg.cfg_div = '0;
    model_reset();
    #3;
    chk("reset_div_out", div_out, 0);
    chk("reset_tick", tick, 0);
    chk("reset_cfg_err", cfg.cfg_err, 0);
    chk("reset_cfg_ready", cfg.cfg_ready, 1);
    @(posedge clk_in); @(posedge clk_in);
    #1 arst = 1'b0;

    // Default period 2 on channel 0.
    for (int k = 0; k < 6; k++) begin
      step(tv[k].en, 0, 0, 0, 0);
      chk("t1_tick0", tick[0], tv[k].exp_tick0);
      chk("t1_div0", div_out[0], tv[k].exp_div0);
    end
    step(0, 0, 0, 0, 0);

    // ch1: run at 3, reprogram to 5 mid-period, second write must stall.
    step(0, 0, 1, 1, 3);
    step(0, 0, 0, 1, 0);
    step(5'b00010, 0, 0, 1, 0);
    step(5'b00010, 0, 0, 1, 0);
    step(5'b00010, 0, 1, 1, 5);
    step(5'b00010, 0, 1, 1, 7);
    chk("t2_ready_blocked", rdy_s, 0);
    chk("t2_wrap_on_old", tick[1], 1);
    nt = 0; nh = 0;
    for (int k = 0; k < 10; k++) begin
      step(5'b00010, 0, 0, 1, 0);
      if (k == 0) chk("t2_ready_free", rdy_s, 1);
      nt += int'(tick[1]); nh += int'(div_out[1]);
    end
    chk("t2_tick_count", nt, 2);
    chk("t2_high_count", nh, 6);

    // ch0 at 4, ch3 at 6, staggered start then sync.
    step(0, 0, 1, 0, 4);
    step(0, 0, 1, 3, 6);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(5'b00001, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) step(5'b01001, 0, 0, 0, 0);
    step(5'b01001, 1, 0, 0, 0);
    chk("t3_sync_both", tick & 5'b01001, 5'b01001);
    both = 0;
    for (int k = 1; k <= 12; k++) begin
      step(5'b01001, 0, 0, 0, 0);
      if (k < 12 && (tick & 5'b01001) == 5'b01001) both++;
    end
    chk("t3_realign", tick & 5'b01001, 5'b01001);
    chk("t3_no_early_align", both, 0);

    // ch2 at period 1.
    step(0, 0, 1, 2, 1);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(5'b00100, 0, 0, 0, 0);
      chk("t4_p1_tick", tick[2], 1);
      chk("t4_p1_div", div_out[2], 1);
    end
    step(0, 0, 0, 0, 0);
    chk("t4_drop_tick", tick[2], 0);
    chk("t4_drop_div", div_out[2], 0);

    // Rejected writes.
    step(0, 0, 1, 1, 0);
    chk("t5_err_div0", cfg.cfg_err, 1);
    step(0, 0, 0, 0, 0);
    chk("t5_err_clear", cfg.cfg_err, 0);
    step(0, 0, 1, 5, 3);
    chk("t5_err_chan5", cfg.cfg_err, 1);
    step(0, 0, 1, 7, 4);
    chk("t5_err_chan7", cfg.cfg_err, 1);
    nt = 0;
    for (int k = 0; k < 5; k++) begin
      step(5'b00010, 0, 0, 0, 0);
      nt += int'(tick[1]);
    end
    chk("t5_p_kept", nt, 1);
    step(0, 0, 0, 0, 0);

    // Async reset at cnt=3 of period 7.
    step(0, 0, 1, 0, 7);
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(5'b00001, 0, 0, 0, 0);
    chk("t6_pre_high", div_out[0], 1);
    arst = 1'b1;
    #1;
    chk("t6_arst_div", div_out, 0);
    chk("t6_arst_tick", tick, 0);
    model_reset();
    #2 arst = 1'b0;
    step(5'b00001, 0, 0, 0, 0);
    chk("t6_first_tick", tick[0], 1);
    step(5'b00001, 0, 0, 0, 0);
    chk("t6_def_gap", tick[0], 0);
    step(5'b00001, 0, 0, 0, 0);
    chk("t6_def_period", tick[0], 1);

    // Random traffic against the model.
    re = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 15) == 0) re[i] = !re[i];
      step(re, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 9)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
